// File: rtl/mem_access_stage_if.sv
// Data-memory side of the MEM-stage access controller: variable-latency req/ack bus.
// The stage is the master; the data memory (or a bench model of it) is the slave.
interface mem_access_stage_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store controller: runs a req/ack handshake to data memory and stalls the pipeline.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses trap instead of being word-aligned.
module mem_access_stage #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       MemRead_i,
    input  logic                       MemWrite_i,
    input  logic [31:0]                addr_i,
    input  logic [31:0]                wdata_i,
    output logic                       stall_o,
    output logic [31:0]                rdata_o,
    output logic                       buserr_o,
    output logic                       misalign_o,
    mem_access_stage_if.master         mem_if
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_req;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_buserr;
    logic [CW-1:0] r_count;

    logic          w_access;
    logic          w_timeout;

    assign w_access  = MemRead_i | MemWrite_i;
    // The counter holds TIMEOUT_CYCLES-1 during the last allowed BUSY cycle.
    assign w_timeout = (r_count == CW'(TIMEOUT_CYCLES - 1));

    // NOTE: stall_o must be combinational so the pipeline freezes in the same cycle the request appears.
    assign stall_o = !rst_i && (((r_state == IDLE) && w_access) || (r_state == BUSY));

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;
    assign misalign_o = r_misalign;
`else
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_buserr <= 1'b0;
            r_count  <= '0;
`ifdef MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_access) begin
`ifdef MISALIGN_TRAP_EN
                        if (addr_i[1:0] != 2'b00) begin
                            r_misalign <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_addr  <= addr_i;
                            r_wdata <= wdata_i;
                            r_we    <= MemWrite_i;
                            r_req   <= 1'b1;
                            r_count <= '0;
                            r_state <= BUSY;
                        end
`else
                        r_addr  <= addr_i & 32'hFFFF_FFFC;
                        r_wdata <= wdata_i;
                        r_we    <= MemWrite_i;
                        r_req   <= 1'b1;
                        r_count <= '0;
                        r_state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    r_count <= r_count + CW'(1);
                    // An ack in the final allowed cycle takes priority over the timeout.
                    if (mem_if.mem_ack_i) begin
                        r_req   <= 1'b0;
                        if (!r_we) r_rdata <= mem_if.mem_rdata_i;
                        r_state <= DONE;
                    end else if (w_timeout) begin
                        r_req    <= 1'b0;
                        r_buserr <= 1'b1;
                        if (!r_we) r_rdata <= ERR_DATA;
                        r_state  <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_if.mem_req_o   = r_req;
    assign mem_if.mem_we_o    = r_we;
    assign mem_if.mem_addr_o  = r_addr;
    assign mem_if.mem_wdata_o = r_wdata;
    assign rdata_o            = r_rdata;
    assign buserr_o           = r_buserr;

endmodule
